// File: rtl/simple_processor_pkg.sv
// Shared widths and opcode encoding for the accumulator core.
package simple_processor_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 11;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_LDI   = 3'b100,
        OP_JMP   = 3'b101,
        OP_JZ    = 3'b110,
        OP_JN    = 3'b111
    } opcode_t;

endpackage

// File: rtl/simple_processor_alu.sv
// Combinational next-accumulator computation plus branch conditions on the current ACC.
module simple_processor_alu
    import simple_processor_pkg::*;
(
    input  opcode_t                   op,
    input  logic signed [DATA_W-1:0]  acc,
    input  logic signed [DATA_W-1:0]  mem_data,
    input  logic        [ADDR_W-1:0]  operand,
    output logic signed [DATA_W-1:0]  acc_next,
    output logic                      zero,
    output logic                      neg
);

    always_comb begin
        acc_next = acc;
        case (op)
            OP_LOAD: acc_next = mem_data;
            OP_ADD:  acc_next = acc + mem_data;
            OP_SUB:  acc_next = acc - mem_data;
            OP_LDI:  acc_next = {{(DATA_W-ADDR_W){operand[ADDR_W-1]}}, operand};
            default: acc_next = acc;
        endcase
    end

    // Conditions look at ACC before the edge, so branches never see the new value.
    assign zero = (acc == '0);
    assign neg  = acc[DATA_W-1];

endmodule

// File: rtl/simple_processor.sv
// Single-cycle accumulator core: PC/ACC registers, next-PC selection and write gating.
module simple_processor
    import simple_processor_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic        [INSTR_W-1:0] instr,
    output logic        [ADDR_W-1:0]  instr_addr,
    output logic                      mem_wr,
    output logic        [ADDR_W-1:0]  mem_addr,
    input  logic signed [DATA_W-1:0]  mem_data_in,
    output logic signed [DATA_W-1:0]  mem_data_out
);

    logic        [ADDR_W-1:0] pc, pc_next;
    logic signed [DATA_W-1:0] acc, acc_next;
    logic                     zero, neg;
    opcode_t                  op;
    logic        [ADDR_W-1:0] operand;

    assign op      = opcode_t'(instr[INSTR_W-1:ADDR_W]);
    assign operand = instr[ADDR_W-1:0];

    simple_processor_alu u_alu (
        .op       (op),
        .acc      (acc),
        .mem_data (mem_data_in),
        .operand  (operand),
        .acc_next (acc_next),
        .zero     (zero),
        .neg      (neg)
    );

    always_comb begin
        pc_next = pc + 1'b1;
        case (op)
            OP_JMP:  pc_next = operand;
            OP_JZ:   if (zero) pc_next = operand;
            OP_JN:   if (neg)  pc_next = operand;
            default: pc_next = pc + 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc  <= '0;
            acc <= '0;
        end else begin
            pc  <= pc_next;
            acc <= acc_next;
        end
    end

    // Reset masks the write combinationally so a STORE in flight never lands.
    assign mem_wr       = rst && (op == OP_STORE);
    assign mem_addr     = operand;
    assign instr_addr   = pc;
    assign mem_data_out = acc;

endmodule

// File: tb/tb_simple_processor.sv
// Directed bench: models the ROM and RAM around the core and checks hand-computed results.
module tb_simple_processor;
    import simple_processor_pkg::*;

    logic                      clk;
    logic                      rst;
    logic        [INSTR_W-1:0] instr;
    logic        [ADDR_W-1:0]  instr_addr;
    logic                      mem_wr;
    logic        [ADDR_W-1:0]  mem_addr;
    logic signed [DATA_W-1:0]  mem_data_in;
    logic signed [DATA_W-1:0]  mem_data_out;

    logic        [INSTR_W-1:0] rom [256];
    logic signed [DATA_W-1:0]  ram [256];
    logic                      tb_we;
    logic        [ADDR_W-1:0]  tb_addr;
    logic signed [DATA_W-1:0]  tb_data;

    int errs   = 0;
    int checks = 0;

    simple_processor dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .instr_addr   (instr_addr),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    assign instr       = rom[instr_addr];
    assign mem_data_in = ram[mem_addr];

    always @(posedge clk) begin
        if (tb_we)       ram[tb_addr]  <= tb_data;
        else if (mem_wr) ram[mem_addr] <= mem_data_out;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [INSTR_W-1:0] ins(input opcode_t op, input logic [7:0] a);
        return {op, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        step();
        tb_we = 1'b0;
    endtask

    task automatic clear_rom(input logic [INSTR_W-1:0] fill);
        for (int i = 0; i < 256; i++) rom[i] = fill;
    endtask

    // Hold reset for one edge, then release at a falling edge.
    task automatic restart();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        int n;
        rst = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        for (int i = 0; i < 256; i++) ram[i] = '0;
        clear_rom('0);

        // Reset with a STORE presented: nothing may be written
        rom[0] = ins(OP_STORE, 8'd30);
        @(negedge clk);
        poke(8'd30, 32'h55);
        chk("rst_wr0", 32'(mem_wr), 0);
        step();
        chk("rst_wr1", 32'(mem_wr), 0);
        step();
        chk("rst_pc", 32'(instr_addr), 0);
        chk("rst_acc", mem_data_out, 0);
        chk("rst_wr2", 32'(mem_wr), 0);
        chk("rst_ram", ram[30], 32'h55);
        chk("rst_maddr", 32'(mem_addr), 30);

        // Load / add / store / halt
        clear_rom('0);
        rom[0] = ins(OP_LOAD, 8'd10);
        rom[1] = ins(OP_ADD, 8'd11);
        rom[2] = ins(OP_STORE, 8'd12);
        rom[3] = ins(OP_JMP, 8'd3);
        poke(8'd10, 32'd7);
        poke(8'd11, -32'sd3);
        restart();
        chk("las_pc0", 32'(instr_addr), 0);
        step(); chk("las_pc1", 32'(instr_addr), 1);
        step(); chk("las_pc2", 32'(instr_addr), 2);
        chk("las_wr", 32'(mem_wr), 1);
        step(); chk("las_pc3", 32'(instr_addr), 3);
        step(); chk("las_pc3b", 32'(instr_addr), 3);
        step(); chk("las_pc3c", 32'(instr_addr), 3);
        chk("las_ram12", ram[12], 4);
        chk("las_acc", mem_data_out, 4);
        chk("las_halt_wr", 32'(mem_wr), 0);

        // Immediate sign extension
        rst = 1'b0;
        clear_rom('0);
        rom[0] = ins(OP_LDI, 8'hFF);
        rom[1] = ins(OP_STORE, 8'd20);
        rom[2] = ins(OP_LDI, 8'h7F);
        rom[3] = ins(OP_STORE, 8'd21);
        rom[4] = ins(OP_JMP, 8'd4);
        restart();
        for (int i = 0; i < 6; i++) step();
        chk("ldi_ff", ram[20], 32'hFFFF_FFFF);
        chk("ldi_7f", ram[21], 32'd127);

        // Wrap-around add then JN
        rst = 1'b0;
        clear_rom('0);
        rom[0]  = ins(OP_LOAD, 8'd0);
        rom[1]  = ins(OP_ADD, 8'd1);
        rom[2]  = ins(OP_STORE, 8'd2);
        rom[3]  = ins(OP_JN, 8'd50);
        rom[50] = ins(OP_JMP, 8'd50);
        poke(8'd0, 32'h7FFF_FFFF);
        poke(8'd1, 32'd1);
        restart();
        for (int i = 0; i < 4; i++) step();
        chk("wrap_ram2", ram[2], 32'h8000_0000);
        chk("wrap_jn", 32'(instr_addr), 50);

        // JZ taken
        rst = 1'b0;
        clear_rom('0);
        rom[0]  = ins(OP_LDI, 8'd0);
        rom[1]  = ins(OP_JZ, 8'd40);
        rom[40] = ins(OP_JMP, 8'd40);
        restart();
        step(); step();
        chk("jz_taken", 32'(instr_addr), 40);

        // JZ / JN not taken on positive ACC
        rst = 1'b0;
        clear_rom('0);
        rom[0] = ins(OP_LDI, 8'd5);
        rom[1] = ins(OP_JZ, 8'd40);
        rom[2] = ins(OP_JN, 8'd60);
        rom[3] = ins(OP_JMP, 8'd3);
        restart();
        step(); step();
        chk("jz_fall", 32'(instr_addr), 2);
        step();
        chk("jn_fall", 32'(instr_addr), 3);

        // Countdown loop: counter in RAM[5], iterations tallied in RAM[7]
        rst = 1'b0;
        clear_rom('0);
        rom[0] = ins(OP_LOAD, 8'd5);
        rom[1] = ins(OP_SUB, 8'd6);
        rom[2] = ins(OP_STORE, 8'd5);
        rom[3] = ins(OP_LOAD, 8'd7);
        rom[4] = ins(OP_ADD, 8'd6);
        rom[5] = ins(OP_STORE, 8'd7);
        rom[6] = ins(OP_LOAD, 8'd5);
        rom[7] = ins(OP_JZ, 8'd9);
        rom[8] = ins(OP_JMP, 8'd1);
        rom[9] = ins(OP_JMP, 8'd9);
        poke(8'd5, 32'd3);
        poke(8'd6, 32'd1);
        poke(8'd7, 32'd0);
        restart();
        n = 0;
        while (instr_addr != 8'd9 && n < 100) begin
            step();
            n++;
        end
        chk("cd_exit", 32'(instr_addr), 9);
        chk("cd_cycles", n, 24);
        chk("cd_iters", ram[7], 3);
        chk("cd_count", ram[5], 0);

        // PC wrap 255 -> 0
        rst = 1'b0;
        clear_rom(ins(OP_LDI, 8'd1));
        restart();
        for (int i = 0; i < 255; i++) step();
        chk("pcw_255", 32'(instr_addr), 255);
        step();
        chk("pcw_0", 32'(instr_addr), 0);
        chk("pcw_acc", mem_data_out, 1);

        // Reset asserted while a STORE is presented
        rst = 1'b0;
        clear_rom('0);
        rom[0] = ins(OP_LDI, 8'd9);
        rom[1] = ins(OP_STORE, 8'd33);
        poke(8'd33, 32'h11);
        rst = 1'b1;
        step();
        chk("mid_pc1", 32'(instr_addr), 1);
        chk("mid_wr_pre", 32'(mem_wr), 1);
        rst = 1'b0;
        #1;
        chk("mid_wr_mask", 32'(mem_wr), 0);
        step();
        chk("mid_ram", ram[33], 32'h11);
        chk("mid_pc0", 32'(instr_addr), 0);
        chk("mid_acc0", mem_data_out, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/simple_processor.md
Name: simple_processor

Overview:
- Single-cycle, accumulator-based 32-bit processor core.
- Fetches 11-bit instructions from an 8-bit-addressed instruction ROM (combinational read).
- Exchanges 32-bit signed words with a 256-word data RAM: combinational read, write on the clock edge.
- Sits between the instruction-memory block and the data-memory block at the top level of the design.

Parameters:
- DATA_W, 32, width of accumulator and data-memory words
- ADDR_W, 8, width of program counter and data-memory address
- INSTR_W, 11, instruction width (3-bit opcode + 8-bit operand)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset
- instr  input  11  instruction at instr_addr, from instruction ROM (combinational)
- instr_addr  output  8  program counter value
- mem_wr  output  1  data-memory write enable, sampled by RAM on rising clk
- mem_addr  output  8  data-memory address
- mem_data_in  input  32 signed  read data from RAM (combinational read of mem_addr)
- mem_data_out  output  32 signed  write data to RAM

Behaviour:
- State:
  - PC: 8 bits, drives instr_addr.
  - ACC: 32-bit signed, drives mem_data_out.
- Reset: on a rising clk with rst=0, PC<=0 and ACC<=0. While rst=0, mem_wr is forced to 0, combinationally.
- Reset outputs: instr_addr=0, mem_data_out=0, mem_wr=0. mem_addr follows instr[7:0].
- Decode:
  - opcode = instr[10:8], operand = instr[7:0].
  - mem_addr = operand at all times, combinational.
- Timing: one instruction per clock. All register updates occur on the rising edge after the instruction is presented. Default PC update is PC+1, wrapping 255->0.
- Opcodes:
  - 000 LOAD: ACC<=mem_data_in.
  - 001 STORE: mem_wr=1 this cycle; RAM[operand]<=ACC at the edge; ACC unchanged.
  - 010 ADD: ACC<=ACC+mem_data_in.
  - 011 SUB: ACC<=ACC-mem_data_in.
  - 100 LDI: ACC<=sign-extended operand (e.g. 8'hFF -> -1).
  - 101 JMP: PC<=operand.
  - 110 JZ: if ACC==0 then PC<=operand, else PC+1.
  - 111 JN: if ACC[31]==1 then PC<=operand, else PC+1.
- Arithmetic:
  - Two's complement, modulo 2^32.
  - Overflow silently wraps; no flags or exceptions.
- Write enable: mem_wr=1 only for STORE with rst=1; 0 for every other opcode.
- Branch conditions use ACC as it was before the edge; there is no hazard, since execution is single-cycle.
- Halt idiom: JMP to own address. PC stays fixed, no writes occur, and ACC holds.
- Reset mid-program: the next edge with rst=0 restores PC=0 and ACC=0. A STORE pending in that cycle is suppressed.
- Data RAM (companion block): 256x32, write on rising clk when mem_wr=1, read combinational, contents not reset.
- Instruction ROM (companion block): 256x11, combinational, preloaded from a hex file.
- Unprogrammed ROM locations read as 0 (LOAD 0).

Decomposition:
- Shared package simple_processor_pkg:
  - width constants DATA_W, ADDR_W, INSTR_W;
  - 3-bit opcode enum (OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_LDI, OP_JMP, OP_JZ, OP_JN).
- One natural sub-module, simple_processor_alu, which is purely combinational:
  - inputs: opcode, ACC, mem_data_in, operand;
  - outputs: next ACC, zero and negative conditions.
- The top module holds the PC/ACC registers, next-PC logic and mem_wr gating.

Test Plan:
- Reset: hold rst=0 for 2 edges with a STORE presented -> instr_addr=0, ACC=0, mem_wr never 1, RAM unchanged.
- Load/add/store:
  - Setup: RAM[10]=7, RAM[11]=-3.
  - Program: LOAD 10; ADD 11; STORE 12; JMP 3.
  - Required: RAM[12]=4; instr_addr sequence 0,1,2,3,3,3.
- Immediate and sign extension: LDI 8'hFF; STORE 20 -> RAM[20]=32'hFFFFFFFF. Then LDI 8'h7F; STORE 21 -> RAM[21]=127.
- Wrap-around arithmetic: RAM[0]=32'h7FFFFFFF, RAM[1]=1; LOAD 0; ADD 1; STORE 2 -> RAM[2]=32'h80000000. A following JN 50 lands PC at 50.
- Conditional branches:
  - LDI 0; JZ 40 -> PC=40.
  - LDI 5; JZ 40 -> PC falls through (+1).
  - LDI 5; JN 60 -> PC falls through.
  - Countdown loop RAM[5]=3, repeatedly SUB of RAM[6]=1 until JZ exits -> exit after exactly 3 iterations.
- PC wrap and mid-run reset:
  - Instruction ROM filled with LDI 1 -> PC goes 255 then 0.
  - Assert rst=0 during a STORE -> no write occurs; PC=0 on the next edge.
